eth_rx_frame_reader: RTL and testbench

Frame reader on the `sys_clk` side of the receive FIFO pair written by the MAC-side receive wrapper. It pops one 16-bit length word from the length FIFO, then pops exactly that many bytes from the data FIFO. It presents the bytes as a valid/ready byte stream with start/end-of-frame markers to the ORB packet parser. Frames with illegal lengths are drained from the data FIFO and counted as drops, never forwarded.

---
 rtl/eth_rx_frame_reader_pkg.sv | 18 +
 rtl/eth_rx_skid_buf2.sv | 45 ++++
 rtl/eth_rx_frame_reader.sv | 151 +++++++++++++++
 tb/tb_eth_rx_frame_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_frame_reader_pkg.sv
// Shared types and defaults for the receive-side frame reader.
// Holds the FSM encoding, the default frame length limits and the skid-buffer payload width.
package eth_rx_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LEN_WAIT = 2'd1,
        ST_STREAM   = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    localparam logic [15:0] DEF_MIN_FRAME_LEN = 16'd14;
    localparam logic [15:0] DEF_MAX_FRAME_LEN = 16'd1518;

    // Buffer payload layout: {sof, eof, data[7:0]}
    localparam int PAYLOAD_W = 10;

endpackage

// File: rtl/eth_rx_skid_buf2.sv
// Two-entry FIFO that sits between the data FIFO return path and the output stream.
// The head entry is presented combinationally, so it holds still while the consumer stalls.
module eth_rx_skid_buf2
    import eth_rx_frame_reader_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] din,
    input  logic                 pop,
    output logic [PAYLOAD_W-1:0] dout,
    output logic [1:0]           occ
);

    logic [PAYLOAD_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/eth_rx_frame_reader.sv
// Pops a length word, then that many bytes, and streams them out with sof/eof markers.
// Illegal lengths are drained from the data FIFO and counted as drops.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for en and a queued length; pops the length FIFO
// LEN_WAIT  | length word valid; latch it and classify the frame
// STREAM    | issue data reads into the skid buffer, forward to consumer
// FLUSH     | discard the bytes of an illegal frame
module eth_rx_frame_reader
    import eth_rx_frame_reader_pkg::*;
#(
    parameter logic [15:0] MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
    parameter logic [15:0] MAX_FRAME_LEN = DEF_MAX_FRAME_LEN
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        en,
    input  logic        rx_len_fifo_empty,
    input  logic [15:0] rx_len_fifo_data,
    output logic        rx_len_fifo_read,
    input  logic        rx_data_fifo_empty,
    input  logic [7:0]  rx_data_fifo_data,
    output logic        rx_data_fifo_read,
    output logic [7:0]  frm_data,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic        frm_sof,
    output logic        frm_eof,
    output logic [15:0] frm_len,
    output logic [15:0] frm_ok_cnt,
    output logic [15:0] frm_drop_cnt
);

    state_t               state, state_nxt;
    logic [15:0]          rd_left;
    logic [15:0]          out_left;
    logic                 inflight;
    logic                 inflight_sof;
    logic                 inflight_eof;
    logic [1:0]           occ;
    logic [PAYLOAD_W-1:0] buf_dout;
    logic                 pop;
    logic                 len_read;
    logic                 data_read;
    logic                 drop_now;
    logic                 end_pop;
    logic [2:0]           fill;
    logic [2:0]           room;

    assign pop     = frm_valid & frm_ready;
    assign end_pop = pop && (out_left == 16'd1);
    // occ + inflight - pop < 2, rearranged to stay non-negative
    assign fill    = {1'b0, occ} + {2'b00, inflight};
    assign room    = 3'd2 + {2'b00, pop};

    always_comb begin
        state_nxt = state;
        len_read  = 1'b0;
        data_read = 1'b0;
        drop_now  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && !rx_len_fifo_empty) begin
                    len_read  = 1'b1;
                    state_nxt = ST_LEN_WAIT;
                end
            end
            ST_LEN_WAIT: begin
                if (rx_len_fifo_data == 16'd0) begin
                    drop_now  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (rx_len_fifo_data < MIN_FRAME_LEN || rx_len_fifo_data > MAX_FRAME_LEN) begin
                    state_nxt = ST_FLUSH;
                end else begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                data_read = (rd_left != 16'd0) && !rx_data_fifo_empty && (fill < room);
                if (end_pop) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                data_read = (rd_left != 16'd0) && !rx_data_fifo_empty;
                if (data_read && rd_left == 16'd1) begin
                    drop_now  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            frm_len      <= 16'd0;
            rd_left      <= 16'd0;
            out_left     <= 16'd0;
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
            inflight_eof <= 1'b0;
            frm_ok_cnt   <= 16'd0;
            frm_drop_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            inflight <= data_read && (state == ST_STREAM);
            // Tags follow the read into the return cycle
            inflight_sof <= (rd_left == frm_len);
            inflight_eof <= (rd_left == 16'd1);
            if (state == ST_LEN_WAIT) begin
                frm_len  <= rx_len_fifo_data;
                rd_left  <= rx_len_fifo_data;
                out_left <= rx_len_fifo_data;
            end else begin
                if (data_read) begin
                    rd_left <= rd_left - 16'd1;
                end
                if (pop) begin
                    out_left <= out_left - 16'd1;
                end
            end
            if (end_pop) begin
                frm_ok_cnt <= frm_ok_cnt + 16'd1;
            end
            if (drop_now) begin
                frm_drop_cnt <= frm_drop_cnt + 16'd1;
            end
        end
    end

    eth_rx_skid_buf2 u_skid (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .push    (inflight),
        .din     ({inflight_sof, inflight_eof, rx_data_fifo_data}),
        .pop     (pop),
        .dout    (buf_dout),
        .occ     (occ)
    );

    assign rx_len_fifo_read  = len_read;
    assign rx_data_fifo_read = data_read;
    assign frm_valid         = (occ != 2'd0);
    assign frm_sof           = buf_dout[9];
    assign frm_eof           = buf_dout[8];
    assign frm_data          = buf_dout[7:0];

endmodule

// File: tb/tb_eth_rx_frame_reader.sv
// Bench for eth_rx_frame_reader: behavioural FIFOs feed frames, a scoreboard checks every beat.
// A vector table covers the frame classes; short hand sequences cover timing and reset corners.
module tb_eth_rx_frame_reader;

    localparam int MIN_LEN = 14;
    localparam int MAX_LEN = 1518;

    logic        clk_i = 1'b0;
    logic        reset_n = 1'b1;
    logic        en = 1'b0;
    logic        rx_len_fifo_empty;
    logic [15:0] rx_len_fifo_data;
    logic        rx_len_fifo_read;
    logic        rx_data_fifo_empty;
    logic [7:0]  rx_data_fifo_data;
    logic        rx_data_fifo_read;
    logic [7:0]  frm_data;
    logic        frm_valid;
    logic        frm_ready = 1'b0;
    logic        frm_sof;
    logic        frm_eof;
    logic [15:0] frm_len;
    logic [15:0] frm_ok_cnt;
    logic [15:0] frm_drop_cnt;

    eth_rx_frame_reader dut (
        .clk_i              (clk_i),
        .reset_n            (reset_n),
        .en                 (en),
        .rx_len_fifo_empty  (rx_len_fifo_empty),
        .rx_len_fifo_data   (rx_len_fifo_data),
        .rx_len_fifo_read   (rx_len_fifo_read),
        .rx_data_fifo_empty (rx_data_fifo_empty),
        .rx_data_fifo_data  (rx_data_fifo_data),
        .rx_data_fifo_read  (rx_data_fifo_read),
        .frm_data           (frm_data),
        .frm_valid          (frm_valid),
        .frm_ready          (frm_ready),
        .frm_sof            (frm_sof),
        .frm_eof            (frm_eof),
        .frm_len            (frm_len),
        .frm_ok_cnt         (frm_ok_cnt),
        .frm_drop_cnt       (frm_drop_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        int len;
        int rmode;
        int gap_at;
        int pops;
        int ok_d;
        int drop_d;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [15:0] lq[$];
    logic [7:0]  dq[$];
    beat_t       sb[$];
    int          lp_q[$];
    int          eof_q[$];
    logic        hold = 1'b0;
    int          ready_mode = 0;
    logic [3:0]  rpat = 4'b1001;
    logic [1:0]  rph = 2'd0;
    int          gap_at = -1;
    int          gap_cnt = 0;
    int          cyc = 0;
    int          data_pops = 0;
    int          len_pops = 0;
    int          first_valid_cyc = -1;
    int          sof_cyc = -1;
    int          eof_cyc = -1;
    logic        seen_valid = 1'b0;
    logic        gap_seen = 1'b0;
    logic        in_frame = 1'b0;
    logic        stall_prev = 1'b0;
    logic [10:0] prev_out = '0;
    logic [15:0] exp_ok = 16'd0;
    logic [15:0] exp_drop = 16'd0;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Standard (non-show-ahead) FIFOs; both cleared by the shared reset
    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            lq.delete();
            dq.delete();
            rx_len_fifo_empty  <= 1'b1;
            rx_data_fifo_empty <= 1'b1;
            rx_len_fifo_data   <= 16'd0;
            rx_data_fifo_data  <= 8'd0;
        end else begin
            if (rx_len_fifo_read && lq.size() != 0) rx_len_fifo_data <= lq.pop_front();
            if (rx_data_fifo_read && dq.size() != 0) rx_data_fifo_data <= dq.pop_front();
            rx_len_fifo_empty  <= (lq.size() == 0);
            rx_data_fifo_empty <= (dq.size() == 0) || hold;
        end
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        if (ready_mode == 0) begin
            frm_ready = 1'b1;
        end else begin
            frm_ready = rpat[rph];
            rph = rph + 2'd1;
        end
    end

    always @(negedge clk_i) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
            in_frame   = 1'b0;
            hold       = 1'b0;
        end else begin
            cyc++;
            if (rx_len_fifo_read) begin
                len_pops++;
                lp_q.push_back(cyc);
                check("len_read_nonempty", rx_len_fifo_empty, 1'b0);
            end
            if (rx_data_fifo_read) begin
                data_pops++;
                check("data_read_nonempty", rx_data_fifo_empty, 1'b0);
            end
            if (stall_prev) begin
                check("stall_stable", {frm_valid, frm_sof, frm_eof, frm_data}, prev_out);
            end
            if (frm_valid && !seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (in_frame && !frm_valid) gap_seen = 1'b1;
            if (frm_valid && frm_ready) begin
                check("beat_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    check("beat", {frm_sof, frm_eof, frm_data}, e);
                end
                if (frm_sof) begin
                    sof_cyc  = cyc;
                    in_frame = 1'b1;
                end
                if (frm_eof) begin
                    eof_cyc  = cyc;
                    in_frame = 1'b0;
                    eof_q.push_back(cyc);
                end
            end
            stall_prev = frm_valid && !frm_ready;
            prev_out   = {frm_valid, frm_sof, frm_eof, frm_data};
            if (gap_at >= 0 && data_pops >= gap_at && gap_cnt < 5) begin
                hold = 1'b1;
                gap_cnt++;
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic push_frame(input int len);
        lq.push_back(16'(len));
        for (int i = 0; i < len; i++) begin
            dq.push_back(8'(i));
            if (len >= MIN_LEN && len <= MAX_LEN) begin
                sb.push_back({i == 0, i == len - 1, 8'(i)});
            end
        end
    endtask

    task automatic clear_track();
        data_pops       = 0;
        len_pops        = 0;
        seen_valid      = 1'b0;
        gap_seen        = 1'b0;
        first_valid_cyc = -1;
        sof_cyc         = -1;
        eof_cyc         = -1;
        gap_cnt         = 0;
        lp_q.delete();
        eof_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int b;
        b = budget;
        while (b > 0 && !(frm_ok_cnt == exp_ok && frm_drop_cnt == exp_drop &&
                          sb.size() == 0 && dq.size() == 0 && lq.size() == 0)) begin
            @(negedge clk_i);
            b--;
        end
        check({tag, "_done"}, b != 0, 1'b1);
        repeat (3) @(negedge clk_i);
        check({tag, "_ok_cnt"}, frm_ok_cnt, exp_ok);
        check({tag, "_drop_cnt"}, frm_drop_cnt, exp_drop);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk_i);
        clear_track();
        ready_mode = v.rmode;
        gap_at     = v.gap_at;
        push_frame(v.len);
        exp_ok   = exp_ok + 16'(v.ok_d);
        exp_drop = exp_drop + 16'(v.drop_d);
        wait_done(tag, 4 * v.len + 40);
        check({tag, "_data_pops"}, data_pops, v.pops);
        check({tag, "_len_pops"}, len_pops, 1);
        check({tag, "_frm_len"}, frm_len, v.len);
        check({tag, "_valid_seen"}, seen_valid, v.ok_d != 0);
        check({tag, "_idle_valid"}, frm_valid, 1'b0);
        if (v.rmode == 0 && v.gap_at < 0 && v.ok_d != 0) begin
            check({tag, "_latency"}, first_valid_cyc - lp_q[0], 4);
            check({tag, "_burst"}, eof_cyc - sof_cyc, v.len - 1);
        end
        if (v.gap_at >= 0) check({tag, "_gap"}, gap_seen, 1'b1);
        ready_mode = 0;
        gap_at     = -1;
    endtask

    initial begin
        int b;
        //          len   rmode gap  pops  ok drop
        vecs[0] = '{60,   0,   -1,   60,   1, 0};
        vecs[1] = '{60,   1,   -1,   60,   1, 0};
        vecs[2] = '{2000, 0,   -1,   2000, 0, 1};
        vecs[3] = '{64,   0,   -1,   64,   1, 0};
        vecs[4] = '{0,    0,   -1,   0,    0, 1};
        vecs[5] = '{60,   0,   20,   60,   1, 0};
        vecs[6] = '{14,   0,   -1,   14,   1, 0};
        vecs[7] = '{1518, 0,   -1,   1518, 1, 0};
        vecs[8] = '{13,   1,   -1,   13,   0, 1};
        vecs[9] = '{1519, 0,   -1,   1519, 0, 1};

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check("reset_state", {frm_valid, frm_sof, frm_eof, frm_data, frm_len, frm_ok_cnt,
                              frm_drop_cnt, rx_len_fifo_read, rx_data_fifo_read}, 64'd0);
        @(negedge clk_i);
        reset_n = 1'b1;

        // en low holds off the length pop
        clear_track();
        push_frame(14);
        repeat (10) @(negedge clk_i);
        check("en_gate", len_pops, 0);
        en = 1'b1;
        exp_ok = exp_ok + 16'd1;
        wait_done("en_release", 100);

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i], i);
        end

        // zero length returns to IDLE two cycles after its pop
        @(negedge clk_i);
        clear_track();
        push_frame(0);
        push_frame(14);
        exp_ok   = exp_ok + 16'd1;
        exp_drop = exp_drop + 16'd1;
        wait_done("zero_len", 200);
        check("zero_len_pops", lp_q.size(), 2);
        if (lp_q.size() == 2) check("zero_len_idle", lp_q[1] - lp_q[0], 2);
        check("zero_len_data_pops", data_pops, 14);

        // back-to-back: next length pop right after the eof pop
        @(negedge clk_i);
        clear_track();
        push_frame(14);
        push_frame(20);
        exp_ok = exp_ok + 16'd2;
        wait_done("b2b", 300);
        check("b2b_pops", lp_q.size() + eof_q.size(), 4);
        if (lp_q.size() == 2 && eof_q.size() == 2) check("b2b_gap", lp_q[1] - eof_q[0], 1);

        // reset while byte 10 is presented
        @(negedge clk_i);
        clear_track();
        push_frame(60);
        b = 400;
        while (b > 0 && sb.size() > 50) begin
            @(negedge clk_i);
            b--;
        end
        check("reach_byte10", b != 0, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_async", {frm_valid, frm_sof, frm_eof, frm_data, frm_len, frm_ok_cnt,
                              frm_drop_cnt, rx_len_fifo_read, rx_data_fifo_read}, 64'd0);
        sb.delete();
        exp_ok   = 16'd0;
        exp_drop = 16'd0;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n = 1'b1;
        run_frame(vecs[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
